sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single byte-wide SDRAM controller port between the ROM/VHD download loader and the Z80 system bus. Loader writes are buffered in a small FIFO so the SPI side never stalls; CPU reads/writes are held by a request/acknowledge handshake. The block issues one-cycle strobes to the SDRAM controller, waits on its ready flag, and sits between the mist_io download path, the rememotech memory bus and the sram controller.

## Interface
- AW, 23, address width
- DW, 8, data width
- FIFO_AW, 2, log2 of loader FIFO depth (depth 4)
- MAX_BURST, 4, consecutive loader grants allowed while a CPU request waits

- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ld_wr  in  1  one-cycle loader write pulse
- ld_addr  in  AW  loader write address
- ld_data  in  DW  loader write data
- ld_full  out  1  FIFO full (registered count == depth)
- ld_busy  out  1  FIFO non-empty or loader access in flight
- ld_ovf  out  1  sticky: a push was dropped while full; cleared only by reset
- cpu_req  in  1  level request from CPU bus (chip select and OE or WE)
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  read data, held until next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  controller address
- mem_din  out  DW  controller write data
- mem_we  out  1  one-cycle write strobe
- mem_rd  out  1  one-cycle read strobe
- mem_dout  in  DW  controller read data, valid when mem_ready rises after a read
- mem_ready  in  1  controller idle / previous access complete

## Operation
- States: IDLE, ISSUE, GAP, WAIT.
- IDLE: grant only when mem_ready=1. Candidates: loader (FIFO non-empty), CPU (cpu_req=1 and armed). Loader wins unless CPU pending and burst_cnt == MAX_BURST. On grant latch owner, address, data, direction; go ISSUE.
- ISSUE: mem_we or mem_rd high exactly this cycle, mem_addr/mem_din driven from latch; loader grant pops FIFO on entry edge. Go GAP.
- GAP: one cycle, mem_ready ignored (controller deassert latency). Go WAIT.
- WAIT: hold until mem_ready=1; on that edge, if owner=CPU register cpu_ack<=1 and, for reads, cpu_dout<=mem_dout; clear armed. Go IDLE.
- Re-arm: armed sets when cpu_req is sampled 0; a held cpu_req after ack is never serviced twice.
- burst_cnt: +1 on each loader grant while CPU pending and armed; cleared on CPU grant or when CPU not pending; saturates at MAX_BURST.
- FIFO: push on ld_wr when count < depth; simultaneous push and pop allowed, count unchanged; push when full is dropped even if a pop occurs that cycle, and sets ld_ovf. Pointers wrap modulo depth.
- Strobes never asserted outside ISSUE; mem_we and mem_rd mutually exclusive.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, armed=1, burst_cnt=0; ld_full, ld_busy, ld_ovf, cpu_ack, mem_we, mem_rd = 0; cpu_dout, mem_addr, mem_din = 0.
- Reset mid-access aborts; after release the block waits for mem_ready=1 before any grant, so an in-flight controller cycle completes harmlessly.
- Grant latency: request sampled in IDLE at edge n -> strobe high cycle n+1.
- Minimum access: 4 cycles (IDLE, ISSUE, GAP, WAIT with mem_ready already 1); cpu_ack high in the IDLE cycle following WAIT.
- cpu_dout changes only on the edge that raises cpu_ack for a read.
- ld_full/ld_busy registered, updated the cycle after push/pop.

## Test plan
- CPU read, mem_ready returns 3 cycles after mem_rd, mem_dout=0xA5 at addr 0x012345 -> one mem_rd pulse with mem_addr=0x012345, cpu_ack one cycle, cpu_dout=0xA5.
- cpu_req held high 20 cycles after ack -> exactly one mem access; drop for 1 cycle and reassert -> second access.
- 6 ld_wr pulses back-to-back with mem_ready held 0 -> 4 accepted, ld_full=1, ld_ovf=1; release mem_ready -> 4 writes in order, addresses/data match first 4 pushes, ld_busy falls after last.
- Loader FIFO kept non-empty while cpu_req asserted -> CPU granted after exactly 4 loader writes; cpu_ack within 4 accesses' time.
- Push and pop in same cycle at count 2 -> count stays 2; ld_full at count 4 with simultaneous pop -> push dropped, ld_ovf=1.
- reset_n pulsed low during WAIT with mem_ready=0 -> outputs zero immediately; no strobe until mem_ready=1 after release.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - loader, CPU and SDRAM-controller signal bundle for sdram_port_arbiter
interface sdram_port_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 8
);
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_full;
  logic          ld_busy;
  logic          ld_ovf;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;

  modport slave (
    input  ld_wr, ld_addr, ld_data, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ready,
    output ld_full, ld_busy, ld_ovf, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, mem_rd
  );

  modport master (
    output ld_wr, ld_addr, ld_data, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ready,
    input  ld_full, ld_busy, ld_ovf, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, mem_rd
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM controller port between the download loader FIFO and the Z80 bus
module sdram_port_arbiter #(
  parameter int AW        = 23,
  parameter int DW        = 8,
  parameter int FIFO_AW   = 2,
  parameter int MAX_BURST = 4
) (
  input logic               clk_sys,
  input logic               reset_n,
  sdram_port_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT} state_t;

  state_t              state, state_nx;
  logic [AW-1:0]       fifo_addr [DEPTH];
  logic [DW-1:0]       fifo_data [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                armed;
  logic [BW-1:0]       burst_cnt;
  logic                own_cpu, lat_rd, ovf;
  logic [AW-1:0]       lat_addr;
  logic [DW-1:0]       lat_data;
  logic [DW-1:0]       cpu_dout_q;
  logic                cpu_ack_q;
  logic                cpu_pend, ld_pend, fifo_full;
  logic                grant, grant_cpu, grant_ld, done, push, pop;

  assign cpu_pend  = bus.cpu_req && armed;
  assign ld_pend   = |count;
  assign fifo_full = count[FIFO_AW];
  assign grant_ld  = grant && !grant_cpu;
  assign pop       = grant_ld;
  // a full FIFO drops the push even when a pop happens on the same edge
  assign push      = bus.ld_wr && !fifo_full;

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_cpu = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_ready && (cpu_pend || ld_pend)) begin
          grant     = 1'b1;
          grant_cpu = cpu_pend && (!ld_pend || burst_cnt == BW'(MAX_BURST));
          state_nx  = ISSUE;
        end
      end
      ISSUE: state_nx = GAP;
      GAP:   state_nx = WAIT;   // controller needs a cycle to drop mem_ready
      WAIT: begin
        if (bus.mem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      armed      <= 1'b1;
      burst_cnt  <= '0;
      own_cpu    <= 1'b0;
      lat_rd     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.ld_wr && fifo_full) ovf <= 1'b1;

      // a held request must drop once before it can be serviced again
      if (!bus.cpu_req)         armed <= 1'b1;
      else if (done && own_cpu) armed <= 1'b0;

      if (grant_cpu || !cpu_pend)                   burst_cnt <= '0;
      else if (grant_ld && burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;

      if (grant) begin
        own_cpu  <= grant_cpu;
        lat_rd   <= grant_cpu && !bus.cpu_we;
        lat_addr <= grant_cpu ? bus.cpu_addr : fifo_addr[rd_ptr];
        lat_data <= grant_cpu ? bus.cpu_din  : fifo_data[rd_ptr];
      end

      cpu_ack_q <= done && own_cpu;
      if (done && own_cpu && lat_rd) cpu_dout_q <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ld_addr;
      fifo_data[wr_ptr] <= bus.ld_data;
    end
  end

  assign bus.ld_full  = fifo_full;
  assign bus.ld_busy  = ld_pend || (state != IDLE && !own_cpu);
  assign bus.ld_ovf   = ovf;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.mem_addr = lat_addr;
  assign bus.mem_din  = lat_data;
  assign bus.mem_we   = (state == ISSUE) && !lat_rd;
  assign bus.mem_rd   = (state == ISSUE) && lat_rd;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed and randomized checks of sdram_port_arbiter against a transaction-level model
module tb_sdram_port_arbiter;
  localparam int AW = 23, DW = 8, MAXB = 4, DEPTH = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0, errors = 0;

  sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sdram_port_arbiter #(.AW(AW), .DW(DW), .FIFO_AW(2), .MAX_BURST(MAXB)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

  always #5 clk_sys = ~clk_sys;

  // controller emulation
  bit auto_ctl = 1'b0, man_ready = 1'b1, auto_ready = 1'b1;
  bit lat_fix = 1'b0, fix_en = 1'b0;
  int lat_val = 1, rdy_cnt = 0;
  logic [DW-1:0] fix_val = '0, rd_val = '0;
  assign bus.mem_ready = auto_ctl ? auto_ready : man_ready;
  assign bus.mem_dout  = rd_val;

  initial forever begin
    @(negedge clk_sys);
    if (bus.mem_we || bus.mem_rd) begin
      auto_ready = 1'b0;
      rdy_cnt    = lat_fix ? lat_val : $urandom_range(1, 4);
      if (bus.mem_rd) rd_val = fix_en ? fix_val : DW'($urandom);
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) auto_ready = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // transaction-level model: a queue for the FIFO, a tick count since grant for the access
  logic [AW-1:0] lq_a[$];
  logic [DW-1:0] lq_d[$];
  bit m_busy, m_own_cpu, m_rd, m_armed;
  int m_age, m_burst;
  bit e_we, e_rd, e_ack, e_full, e_busy, e_ovf;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_dout;

  task automatic model_reset();
    lq_a.delete(); lq_d.delete();
    m_busy = 0; m_own_cpu = 0; m_rd = 0; m_armed = 1; m_age = 0; m_burst = 0;
    e_we = 0; e_rd = 0; e_ack = 0; e_full = 0; e_busy = 0; e_ovf = 0;
    e_addr = '0; e_din = '0; e_dout = '0;
  endtask

  task automatic model_step();
    int n0 = lq_a.size();
    bit cpu_c = bus.cpu_req && m_armed;
    bit g_cpu = 0, g_ld = 0, done_cpu = 0;
    e_ack = 0;
    if (!m_busy) begin
      if (bus.mem_ready && cpu_c && (n0 == 0 || m_burst == MAXB)) g_cpu = 1;
      else if (bus.mem_ready && n0 != 0) g_ld = 1;
    end else if (m_age >= 2 && bus.mem_ready) begin
      m_busy = 0;
      if (m_own_cpu) begin
        done_cpu = 1; e_ack = 1;
        if (m_rd) e_dout = bus.mem_dout;
      end
    end else m_age++;
    if (g_cpu) begin
      m_busy = 1; m_age = 0; m_own_cpu = 1; m_rd = !bus.cpu_we;
      e_addr = bus.cpu_addr; e_din = bus.cpu_din;
    end
    if (g_ld) begin
      m_busy = 1; m_age = 0; m_own_cpu = 0; m_rd = 0;
      e_addr = lq_a.pop_front(); e_din = lq_d.pop_front();
    end
    if (bus.ld_wr) begin
      if (n0 < DEPTH) begin lq_a.push_back(bus.ld_addr); lq_d.push_back(bus.ld_data); end
      else e_ovf = 1;
    end
    if (g_cpu || !cpu_c) m_burst = 0;
    else if (g_ld && m_burst < MAXB) m_burst++;
    if (!bus.cpu_req) m_armed = 1;
    else if (done_cpu) m_armed = 0;
    e_we   = m_busy && m_age == 0 && !m_rd;
    e_rd   = m_busy && m_age == 0 && m_rd;
    e_full = lq_a.size() == DEPTH;
    e_busy = lq_a.size() != 0 || (m_busy && !m_own_cpu);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // compare process plus strobe log
  int n_we = 0, n_rd = 0;
  logic [AW-1:0] wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  logic [AW-1:0] last_rd_addr = '0;

  initial forever begin
    @(negedge clk_sys);
    chk("mem_we",   32'(bus.mem_we),   32'(e_we));
    chk("mem_rd",   32'(bus.mem_rd),   32'(e_rd));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_din",  32'(bus.mem_din),  32'(e_din));
    chk("cpu_ack",  32'(bus.cpu_ack),  32'(e_ack));
    chk("cpu_dout", 32'(bus.cpu_dout), 32'(e_dout));
    chk("ld_full",  32'(bus.ld_full),  32'(e_full));
    chk("ld_busy",  32'(bus.ld_busy),  32'(e_busy));
    chk("ld_ovf",   32'(bus.ld_ovf),   32'(e_ovf));
    chk("strobe_excl", 32'(bus.mem_we && bus.mem_rd), 0);
    if (bus.mem_we) begin n_we++; wlog_a.push_back(bus.mem_addr); wlog_d.push_back(bus.mem_din); end
    if (bus.mem_rd) begin n_rd++; last_rd_addr = bus.mem_addr; end
  end

  task automatic ld(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ld_wr = w; bus.ld_addr = a; bus.ld_data = d;
  endtask

  task automatic wait_ack(input int maxc, input string nm);
    int k = 0;
    while (!bus.cpu_ack && k < maxc) begin @(negedge clk_sys); k++; end
    chk(nm, 32'(bus.cpu_ack), 1);
  endtask

  task automatic wait_ld_idle(input int maxc, input string nm);
    int k = 0;
    while (bus.ld_busy && k < maxc) begin @(negedge clk_sys); k++; end
    chk(nm, 32'(bus.ld_busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys); #2 reset_n = 1'b0;
    @(negedge clk_sys); reset_n = 1'b1;
  endtask

  initial begin
    int base, k, wr_at_rd, hold;
    bit ack_seen, cpu_done;
    ld(0, '0, '0);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
    repeat (3) @(negedge clk_sys);
    chk("reset ld_busy", 32'(bus.ld_busy), 0);
    chk("reset mem_addr", 32'(bus.mem_addr), 0);
    reset_n = 1'b1;

    // push+pop at count 2, then a push at count 4 that coincides with a pop
    wlog_a.delete(); wlog_d.delete();
    @(negedge clk_sys); man_ready = 0; ld(1, 23'h200, 8'hA0);
    @(negedge clk_sys); ld(1, 23'h201, 8'hA1);
    @(negedge clk_sys); ld(1, 23'h202, 8'hA2); man_ready = 1;
    @(negedge clk_sys); ld(1, 23'h203, 8'hA3); man_ready = 0;
    chk("t5 first write strobe", 32'(bus.mem_we), 1);
    chk("t5 first write addr", 32'(bus.mem_addr), 32'h200);
    @(negedge clk_sys); ld(1, 23'h204, 8'hA4);
    @(negedge clk_sys); ld(0, '0, '0);
    chk("t5 full at four", 32'(bus.ld_full), 1);
    chk("t5 no ovf yet", 32'(bus.ld_ovf), 0);
    @(negedge clk_sys); man_ready = 1;
    @(negedge clk_sys); ld(1, 23'h205, 8'hA5);
    @(negedge clk_sys); ld(0, '0, '0);
    chk("t5 dropped push sets ovf", 32'(bus.ld_ovf), 1);
    chk("t5 not full after pop", 32'(bus.ld_full), 0);
    auto_ctl = 1;
    wait_ld_idle(80, "t5 drain");
    chk("t5 write count", wlog_a.size(), 5);
    for (int i = 0; i < 5 && i < wlog_a.size(); i++) begin
      chk("t5 write addr", 32'(wlog_a[i]), 32'h200 + i);
      chk("t5 write data", 32'(wlog_d[i]), 32'hA0 + i);
    end

    // CPU read with controller returning ready 3 cycles after the strobe
    lat_fix = 1; lat_val = 3; fix_en = 1; fix_val = 8'hA5;
    base = n_rd;
    @(negedge clk_sys); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h012345;
    wait_ack(30, "t1 read ack");
    chk("t1 one read strobe", n_rd - base, 1);
    chk("t1 read addr", 32'(last_rd_addr), 32'h012345);
    chk("t1 read data", 32'(bus.cpu_dout), 32'hA5);
    @(negedge clk_sys);
    chk("t1 ack one cycle", 32'(bus.cpu_ack), 0);
    bus.cpu_req = 0;

    // held request serviced once; drop and reassert gives a second access
    @(negedge clk_sys); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 23'h000777; bus.cpu_din = 8'h3C;
    base = n_we + n_rd;
    wait_ack(30, "t2 write ack");
    repeat (20) @(negedge clk_sys);
    chk("t2 single access while held", n_we + n_rd - base, 1);
    bus.cpu_req = 0;
    @(negedge clk_sys); bus.cpu_req = 1;
    wait_ack(30, "t2 second ack");
    chk("t2 second access", n_we + n_rd - base, 2);
    @(negedge clk_sys); bus.cpu_req = 0;

    // overflow with controller stalled, then in-order drain
    do_reset();
    auto_ctl = 0; man_ready = 0; wlog_a.delete(); wlog_d.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys); ld(1, AW'(32'h100 + i), DW'(32'h10 + i));
    end
    @(negedge clk_sys); ld(0, '0, '0);
    chk("t3 full", 32'(bus.ld_full), 1);
    chk("t3 ovf", 32'(bus.ld_ovf), 1);
    lat_fix = 0; auto_ctl = 1;
    wait_ld_idle(80, "t3 drain");
    chk("t3 write count", wlog_a.size(), 4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      chk("t3 write addr", 32'(wlog_a[i]), 32'h100 + i);
      chk("t3 write data", 32'(wlog_d[i]), 32'h10 + i);
    end

    // loader kept busy while CPU waits: CPU wins after MAX_BURST loader writes
    auto_ctl = 0; man_ready = 0; wlog_a.delete(); wlog_d.delete();
    @(negedge clk_sys); ld(1, 23'h300, 8'h30);
    @(negedge clk_sys); ld(1, 23'h301, 8'h31);
    @(negedge clk_sys); ld(0, '0, '0); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h004242;
    @(negedge clk_sys); lat_fix = 1; lat_val = 1; fix_en = 1; fix_val = 8'h5A; auto_ctl = 1;
    k = 0; wr_at_rd = -1; ack_seen = 0;
    while (!ack_seen && k < 30) begin
      ld(!bus.ld_full, AW'(32'h310 + k), DW'(k));
      @(negedge clk_sys); k++;
      if (bus.mem_rd && wr_at_rd < 0) wr_at_rd = wlog_a.size();
      if (bus.cpu_ack) ack_seen = 1;
    end
    chk("t4 ack seen", 32'(ack_seen), 1);
    chk("t4 loader writes before cpu", wr_at_rd, 4);
    chk("t4 ack cycle", k, 20);
    chk("t4 read data", 32'(bus.cpu_dout), 32'h5A);
    ld(0, '0, '0);
    @(negedge clk_sys); bus.cpu_req = 0;
    wait_ld_idle(80, "t4 drain");

    // reset during WAIT with the controller still busy
    auto_ctl = 0; man_ready = 1;
    @(negedge clk_sys); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 23'h000055; bus.cpu_din = 8'h66;
    k = 0;
    while (!bus.mem_we && k < 10) begin @(negedge clk_sys); k++; end
    chk("t6 write strobe", 32'(bus.mem_we), 1);
    man_ready = 0;
    repeat (3) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 reset mem_addr", 32'(bus.mem_addr), 0);
    chk("t6 reset mem_din", 32'(bus.mem_din), 0);
    chk("t6 reset cpu_dout", 32'(bus.cpu_dout), 0);
    chk("t6 reset ld_ovf", 32'(bus.ld_ovf), 0);
    chk("t6 reset strobes", 32'(bus.mem_we || bus.mem_rd || bus.cpu_ack), 0);
    @(negedge clk_sys); reset_n = 1'b1;
    base = n_we + n_rd;
    repeat (5) @(negedge clk_sys);
    chk("t6 no strobe before ready", n_we + n_rd - base, 0);
    man_ready = 1;
    wait_ack(12, "t6 ack after ready");
    chk("t6 one access after ready", n_we + n_rd - base, 1);
    @(negedge clk_sys); bus.cpu_req = 0;

    // randomized traffic, the model follows every cycle
    lat_fix = 0; fix_en = 0; auto_ctl = 1; cpu_done = 0; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      ld($urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom));
      if (bus.cpu_req && bus.cpu_ack && !cpu_done) begin
        cpu_done = 1; hold = $urandom_range(0, 3);
      end
      if (cpu_done) begin
        if (hold == 0) begin bus.cpu_req = 0; cpu_done = 0; end
        else hold--;
      end else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req = 1; bus.cpu_we = 1'($urandom);
        bus.cpu_addr = AW'($urandom); bus.cpu_din = DW'($urandom);
      end
    end
    ld(0, '0, '0);
    @(negedge clk_sys); bus.cpu_req = 0;
    wait_ld_idle(80, "final drain");
    repeat (10) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule
